// File: rtl/stopwatch_ctrl.sv
// -----------------------------------------------------------------------------
// stopwatch_ctrl
//
// Turns the board's two pushbuttons and the clear switch into a stopwatch:
// synchronises and debounces the keys, runs the IDLE/RUN/PAUSE/LAP state
// machine, gates the centisecond prescaler and the BCD MM:SS.hh counter,
// and picks live or lap-frozen time for the seven-segment decoders.
//
// Ports
//   clk          system clock, rising edge
//   Rn           synchronous active-low reset
//   key_start_n  start/pause button, active-low, asynchronous
//   key_lap_n    lap/clear button, active-low, asynchronous
//   sw_clear     clear switch, active-high level, asynchronous
//   digits       registered BCD {m10,m1,s10,s1,cs10,cs1}
//   state        FSM state: 0 IDLE, 1 RUN, 2 PAUSE, 3 LAP
//   running      high in RUN or LAP
//   frozen       high while digits shows the lap latch
//   tick         one-cycle pulse on each prescaler terminal count
//   wrap         one-cycle pulse when time rolls 59:59.99 -> 00:00.00
// -----------------------------------------------------------------------------
module stopwatch_ctrl #(
    parameter int unsigned CLK_HZ          = 10000000,
    parameter int unsigned TICK_HZ         = 100,
    parameter int unsigned DEBOUNCE_CYCLES = 100000
) (
    input  logic        clk,
    input  logic        Rn,
    input  logic        key_start_n,
    input  logic        key_lap_n,
    input  logic        sw_clear,
    output logic [23:0] digits,
    output logic [1:0]  state,
    output logic        running,
    output logic        frozen,
    output logic        tick,
    output logic        wrap
);

    localparam int unsigned DIV   = CLK_HZ / TICK_HZ;
    localparam int unsigned PRE_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int unsigned DEB_W = $clog2(DEBOUNCE_CYCLES + 1);

    localparam logic [PRE_W-1:0] PRE_MAX = PRE_W'(DIV - 1);
    localparam logic [DEB_W-1:0] DEB_MAX = DEB_W'(DEBOUNCE_CYCLES - 1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] LAP   = 2'd3;

    // Returns {carry_out, next_time}. Each digit rolls at its own limit so the
    // chain never leaves BCD; carry_out is set only on 59:59.99 -> 00:00.00.
    function automatic logic [24:0] bcd_inc(input logic [23:0] t);
        logic [23:0] r;
        logic        c;
        logic [3:0]  lim;
        r = t;
        c = 1'b1;
        for (int i = 0; i < 6; i++) begin
            lim = ((i == 3) || (i == 5)) ? 4'd5 : 4'd9;
            if (c) begin
                if (r[i*4 +: 4] == lim) begin
                    r[i*4 +: 4] = 4'd0;
                end else begin
                    r[i*4 +: 4] = r[i*4 +: 4] + 4'd1;
                    c = 1'b0;
                end
            end
        end
        return {c, r};
    endfunction

    // Index 0 is the start key, index 1 the lap key.
    logic [1:0]       key_p0;
    logic [1:0]       key_p1;
    logic [1:0]       key_lvl;
    logic [1:0]       key_ev;
    logic [DEB_W-1:0] key_cnt [2];
    logic             clr_p0;
    logic             clr_p1;

    logic [PRE_W-1:0] pre;
    logic [PRE_W-1:0] pre_nxt;
    logic [23:0]      live_time;
    logic [23:0]      lap_latch;
    logic [24:0]      inc;
    logic [1:0]       state_nxt;
    logic             start_ev;
    logic             lap_ev;
    logic             active;
    logic             active_nxt;
    logic             time_clr;
    logic             lap_cap;

    // ---- stage p0/p1: synchronisers, then debounce and press-event pulse ----
    always_ff @(posedge clk) begin
        if (!Rn) begin
            key_p0  <= 2'b11;
            key_p1  <= 2'b11;
            key_lvl <= 2'b11;
            key_ev  <= 2'b00;
            clr_p0  <= 1'b1;
            clr_p1  <= 1'b1;
            for (int i = 0; i < 2; i++) begin
                key_cnt[i] <= '0;
            end
        end else begin
            key_p0 <= {key_lap_n, key_start_n};
            key_p1 <= key_p0;
            clr_p0 <= sw_clear;
            clr_p1 <= clr_p0;
            for (int i = 0; i < 2; i++) begin
                key_ev[i] <= 1'b0;
                if (key_p1[i] != key_lvl[i]) begin
                    if (key_cnt[i] == DEB_MAX) begin
                        key_lvl[i] <= key_p1[i];
                        key_cnt[i] <= '0;
                        // only the released->pressed edge is an event
                        key_ev[i]  <= ~key_p1[i];
                    end else begin
                        key_cnt[i] <= key_cnt[i] + DEB_W'(1);
                    end
                end else begin
                    key_cnt[i] <= '0;
                end
            end
        end
    end

    // ---- next-state and prescaler decode ----
    assign start_ev   = key_ev[0];
    assign lap_ev     = key_ev[1] & ~key_ev[0];
    assign active     = (state == RUN) || (state == LAP);
    assign active_nxt = (state_nxt == RUN) || (state_nxt == LAP);
    assign inc        = bcd_inc(live_time);

    always_comb begin
        state_nxt = state;
        time_clr  = 1'b0;
        lap_cap   = 1'b0;
        if (clr_p1) begin
            state_nxt = IDLE;
            time_clr  = 1'b1;
        end else begin
            case (state)
                IDLE: begin
                    if (start_ev) state_nxt = RUN;
                end
                RUN: begin
                    if (start_ev) begin
                        state_nxt = PAUSE;
                    end else if (lap_ev) begin
                        state_nxt = LAP;
                        lap_cap   = 1'b1;
                    end
                end
                LAP: begin
                    if (start_ev) state_nxt = PAUSE;
                    else if (lap_ev) state_nxt = RUN;
                end
                default: begin
                    if (start_ev) begin
                        state_nxt = RUN;
                    end else if (lap_ev) begin
                        state_nxt = IDLE;
                        time_clr  = 1'b1;
                    end
                end
            endcase
        end
    end

    always_comb begin
        pre_nxt = pre;
        if (time_clr) begin
            pre_nxt = '0;
        end else if (active) begin
            pre_nxt = (pre == PRE_MAX) ? '0 : pre + PRE_W'(1);
        end
    end

    // ---- stage p2: state, prescaler, time, latch and display registers ----
    always_ff @(posedge clk) begin
        if (!Rn) begin
            state     <= IDLE;
            running   <= 1'b0;
            frozen    <= 1'b0;
            pre       <= '0;
            tick      <= 1'b0;
            wrap      <= 1'b0;
            live_time <= '0;
            lap_latch <= '0;
            digits    <= '0;
        end else begin
            state   <= state_nxt;
            running <= active_nxt;
            frozen  <= (state_nxt == LAP);
            pre     <= pre_nxt;
            // tick is high exactly while the prescaler sits at its terminal
            // count in RUN/LAP; looking ahead keeps it a clean register
            tick    <= active_nxt && (pre_nxt == PRE_MAX);

            if (time_clr) begin
                live_time <= '0;
                wrap      <= 1'b0;
            end else if (tick) begin
                live_time <= inc[23:0];
                wrap      <= inc[24];
            end else begin
                wrap      <= 1'b0;
            end

            // captures the pre-increment value if a tick lands on the same edge
            if (clr_p1) begin
                lap_latch <= '0;
            end else if (lap_cap) begin
                lap_latch <= live_time;
            end

            digits <= frozen ? lap_latch : live_time;
        end
    end

endmodule

// File: tb/tb_stopwatch_ctrl.sv
module tb_stopwatch_ctrl;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] RUN   = 2'd1;
    localparam logic [1:0] PAUSE = 2'd2;
    localparam logic [1:0] LAP   = 2'd3;

    logic        clk = 1'b0;
    logic        Rn;
    logic        key_start_n;
    logic        key_lap_n;
    logic        sw_clear;
    logic [23:0] digits;
    logic [1:0]  state;
    logic        running;
    logic        frozen;
    logic        tick;
    logic        wrap;

    int checks    = 0;
    int failures  = 0;
    int cyc       = 0;
    int last_tick = -1;
    int nticks    = 0;

    always #5 clk = ~clk;

    stopwatch_ctrl #(
        .CLK_HZ(1000),
        .TICK_HZ(100),
        .DEBOUNCE_CYCLES(4)
    ) dut (
        .clk(clk),
        .Rn(Rn),
        .key_start_n(key_start_n),
        .key_lap_n(key_lap_n),
        .sw_clear(sw_clear),
        .digits(digits),
        .state(state),
        .running(running),
        .frozen(frozen),
        .tick(tick),
        .wrap(wrap)
    );

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // centiseconds -> BCD MM:SS.hh
    function automatic logic [23:0] to_bcd(input int cs);
        int m;
        int s;
        int c;
        m = cs / 6000;
        s = (cs / 100) % 60;
        c = cs % 100;
        return {4'(m / 10), 4'(m % 10), 4'(s / 10), 4'(s % 10), 4'(c / 10), 4'(c % 10)};
    endfunction

    function automatic int from_bcd(input logic [23:0] d);
        return 60000 * int'(d[23:20]) + 6000 * int'(d[19:16]) + 1000 * int'(d[15:12])
             + 100 * int'(d[11:8]) + 10 * int'(d[7:4]) + int'(d[3:0]);
    endfunction

    task automatic step();
        @(negedge clk);
        cyc++;
        if (tick) begin
            last_tick = cyc;
            nticks++;
        end
    endtask

    task automatic steps(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic wait_tick();
        int prev;
        int n;
        prev = last_tick;
        n = 0;
        while (last_tick == prev && n < 40) begin
            step();
            n++;
        end
        chk("tick_seen", 32'(last_tick != prev), 32'd1);
    endtask

    task automatic wait_state(input logic [1:0] s, input string tag);
        int n;
        n = 0;
        while (state !== s && n < 40) begin
            step();
            n++;
        end
        chk(tag, 32'(state), 32'(s));
    endtask

    task automatic press(input bit lap);
        if (lap) key_lap_n = 1'b0;
        else key_start_n = 1'b0;
        steps(8);
        key_lap_n = 1'b1;
        key_start_n = 1'b1;
        steps(8);
    endtask

    initial begin
        int r;
        int t1;
        int n;
        int p;
        int gap;
        int base;
        int np;
        logic [23:0] d0;
        logic [23:0] exp_p;

        Rn = 1'b0;
        key_start_n = 1'b1;
        key_lap_n = 1'b1;
        sw_clear = 1'b0;
        steps(3);
        chk("reset_state", 32'(state), 32'(IDLE));
        chk("reset_digits", 32'(digits), 32'd0);
        chk("reset_running", 32'(running), 32'd0);
        chk("reset_frozen", 32'(frozen), 32'd0);
        chk("reset_tick", 32'(tick), 32'd0);
        chk("reset_wrap", 32'(wrap), 32'd0);
        Rn = 1'b1;
        step();

        // 1: start press, debounce latency, tick cadence, first digits
        key_start_n = 1'b0;
        steps(6);
        chk("deb_early", 32'(state), 32'(IDLE));
        step();
        chk("deb_run", 32'(state), 32'(RUN));
        chk("deb_running", 32'(running), 32'd1);
        r = cyc;
        steps(3);
        key_start_n = 1'b1;
        wait_tick();
        t1 = last_tick;
        chk("first_tick_gap", 32'(last_tick - r), 32'd9);
        step();
        chk("digits_latency", 32'(digits), 32'd0);
        step();
        chk("digits_1", 32'(digits), 32'h000001);
        wait_tick();
        chk("tick_period", 32'(last_tick - t1), 32'd10);
        for (int i = 0; i < 8; i++) wait_tick();
        steps(2);
        chk("digits_10", 32'(digits), 32'h000010);

        // 2: short bounces on start produce no event
        steps(10);
        for (int k = 0; k < 20; k++) begin
            key_start_n = ((k / 2) % 2 == 0) ? 1'b0 : 1'b1;
            step();
        end
        key_start_n = 1'b1;
        steps(8);
        chk("bounce_state", 32'(state), 32'(RUN));
        d0 = digits;
        steps(100);
        chk("bounce_count", 32'(from_bcd(digits) - from_bcd(d0)), 32'd10);

        // 3: lap freeze at 00:01.23, then back to live
        n = 0;
        while (digits !== 24'h000123 && n < 3000) begin
            step();
            n++;
        end
        chk("reach_123", 32'(digits), 32'h000123);
        press(1'b1);
        chk("lap_state", 32'(state), 32'(LAP));
        chk("lap_frozen", 32'(frozen), 32'd1);
        chk("lap_running", 32'(running), 32'd1);
        chk("lap_digits", 32'(digits), 32'h000123);
        steps(30);
        chk("lap_hold", 32'(digits), 32'h000123);
        press(1'b1);
        chk("unlap_state", 32'(state), 32'(RUN));
        chk("unlap_frozen", 32'(frozen), 32'd0);
        chk("unlap_live", 32'(digits), 32'h000129);

        // 4: preload 59:59.99 while paused, resume, wrap
        press(1'b0);
        chk("pause_state", 32'(state), 32'(PAUSE));
        chk("pause_running", 32'(running), 32'd0);
        force dut.live_time = 24'h595999;
        step();
        release dut.live_time;
        steps(2);
        chk("preload", 32'(digits), 32'h595999);
        key_start_n = 1'b0;
        wait_state(RUN, "resume_run");
        wait_tick();
        base = nticks;
        chk("wrap_before", 32'(wrap), 32'd0);
        step();
        chk("wrap_pulse", 32'(wrap), 32'd1);
        step();
        chk("wrap_once", 32'(wrap), 32'd0);
        chk("wrap_digits", 32'(digits), 32'd0);
        key_start_n = 1'b1;
        steps(8);

        // 5: pause holds digits and prescaler, resume continues from it
        key_start_n = 1'b0;
        wait_state(PAUSE, "t5_pause");
        p = cyc;
        gap = 9 - (p - last_tick - 1);
        steps(2);
        np = nticks;
        exp_p = to_bcd(nticks - base);
        chk("pause_digits", 32'(digits), 32'(exp_p));
        key_start_n = 1'b1;
        steps(100);
        chk("pause_no_tick", 32'(nticks - np), 32'd0);
        chk("pause_hold", 32'(digits), 32'(exp_p));
        key_start_n = 1'b0;
        wait_state(RUN, "t5_run");
        r = cyc;
        n = 0;
        while (last_tick < r && n < 20) begin
            step();
            n++;
        end
        chk("resume_gap", 32'(last_tick - r), 32'(gap));
        key_start_n = 1'b1;
        steps(8);
        press(1'b0);
        chk("t5_pause2", 32'(state), 32'(PAUSE));
        press(1'b1);
        chk("idle_state", 32'(state), 32'(IDLE));
        chk("idle_digits", 32'(digits), 32'd0);
        steps(30);
        chk("idle_hold", 32'(digits), 32'd0);

        // 6: simultaneous start+lap, then sw_clear priority
        press(1'b0);
        chk("t6_run", 32'(state), 32'(RUN));
        key_start_n = 1'b0;
        key_lap_n = 1'b0;
        steps(8);
        key_start_n = 1'b1;
        key_lap_n = 1'b1;
        steps(8);
        chk("both_pause", 32'(state), 32'(PAUSE));
        chk("both_frozen", 32'(frozen), 32'd0);
        press(1'b0);
        chk("t6_run2", 32'(state), 32'(RUN));
        steps(20);
        sw_clear = 1'b1;
        steps(3);
        chk("clr_state", 32'(state), 32'(IDLE));
        step();
        chk("clr_digits", 32'(digits), 32'd0);
        press(1'b0);
        chk("clr_ignore", 32'(state), 32'(IDLE));
        chk("clr_digits_hold", 32'(digits), 32'd0);
        sw_clear = 1'b0;
        steps(4);
        press(1'b0);
        chk("after_clr_run", 32'(state), 32'(RUN));

        // reset mid-count, on a tick cycle
        wait_tick();
        Rn = 1'b0;
        step();
        chk("rst_tick", 32'(tick), 32'd0);
        chk("rst_wrap", 32'(wrap), 32'd0);
        chk("rst_state", 32'(state), 32'(IDLE));
        chk("rst_digits", 32'(digits), 32'd0);
        chk("rst_running", 32'(running), 32'd0);
        Rn = 1'b1;
        steps(2);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
